ac_sweep_sequencer: RTL and testbench
=====================================

// Module: ac_sweep_sequencer
// PURPOSE
// Sequences a linear AC frequency sweep over a resonant RLC test circuit: programs the Vac source frequency point by point,
// waits a settle interval, averages magnitude samples from the detector and streams one result per point. Sits between
// the sweep config registers and the source/detector pair; optionally tracks the resonance (peak-magnitude) point.
// PARAMETERS
// FW        32  frequency word width (source tuning word)
// MW        24  detector magnitude width (unsigned)
// SETTLE_W  16  settle counter width
// AVG_LOG2  2   log2 of samples averaged per point (2**AVG_LOG2 samples)
// PORTS
// clk         in   1         single clock, all logic rising-edge
// rst_n       in   1         asynchronous active-low reset
// start       in   1         pulse: begin sweep (ignored while busy)
// abort       in   1         pulse: terminate sweep
// f_start     in   FW        first frequency word (sampled on start)
// f_step      in   FW        increment per point (sampled on start)
// n_points    in   16        points in sweep (sampled on start)
// settle_cyc  in   SETTLE_W  cycles to wait after src_ack before measuring
// src_freq    out  FW        frequency word to source, stable while src_req high
// src_req     out  1         source program request; held until src_ack
// src_ack     in   1         source accepted src_freq
// meas_req    out  1         high while samples wanted
// meas_valid  in   1         meas_mag valid this cycle
// meas_mag    in   MW        detector magnitude
// pt_valid    out  1         one-cycle pulse: point result valid
// pt_idx      out  16        point index 0..n_points-1
// pt_freq     out  FW        frequency of the point
// pt_mag      out  MW        averaged magnitude
// busy        out  1         sweep in progress
// done        out  1         one-cycle pulse: sweep completed normally
// peak_freq   out  FW        frequency of max pt_mag (PEAK_TRACK_EN)
// peak_mag    out  MW        max pt_mag so far
// peak_idx    out  16        index of max
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, accumulators/counters 0.
// - FSM: IDLE -start-> PROGRAM (n_points==0: -> DONE directly); PROGRAM: src_req=1, src_freq=cur; on src_ack -> SETTLE
//   (src_req drops same edge). SETTLE: count settle_cyc cycles (0 = skip, go MEASURE next cycle) -> MEASURE.
//   MEASURE: meas_req=1; accumulate meas_mag on each meas_valid; after 2**AVG_LOG2 samples -> EVAL.
//   EVAL: pt_valid pulse, pt_mag = sum >> AVG_LOG2, peak update; idx==n_points-1 -> DONE else idx++, cur+=f_step -> PROGRAM.
//   DONE: done pulse one cycle, busy=0 -> IDLE.
// - busy=1 from cycle after start through EVAL of last point.
// - Accumulator width MW+AVG_LOG2, no overflow; freq accumulation wraps modulo 2**FW.
// - meas_valid outside MEASURE, src_ack outside PROGRAM: ignored. src_ack and abort same cycle: abort wins.
// - abort in any non-IDLE state: IDLE next cycle, src_req/meas_req drop, no done, no pt_valid; peak regs keep last value.
// - start in same cycle as abort while busy: abort wins, start ignored. start while busy: ignored.
// - Peak: cleared on accepted start; update when pt_mag > peak_mag (strict; first maximum wins ties).
// - Latency per point, ideal handshakes: 1 (PROGRAM) + settle_cyc + 2**AVG_LOG2 + 1 (EVAL) cycles.
// - Async reset mid-sweep: immediate return to reset values; no partial outputs.
// CONFIGURATION
// - PEAK_TRACK_EN defined: peak_freq/peak_mag/peak_idx tracked as above.
// - Not defined: peak outputs tied 0, comparator and registers removed; all other behaviour identical.
// STRUCTURE
// - Package ac_sweep_pkg: sweep_state_e enum (IDLE,PROGRAM,SETTLE,MEASURE,EVAL,DONE), IDX_W=16 constant.
// - Sub-module sweep_avg_acc: sample counter + accumulator + shift, clear/add/full interface.
// TESTING
// - f_start=1000,f_step=100,n_points=4,settle=3,AVG_LOG2=2, immediate ack, mag=const 50 -> 4 pt_valid, freqs 1000..1300, mag 50, done once.
// - n_points=0 start -> no src_req, done pulse 2 cycles after start, busy never stays high.
// - mags per point 10,40,40,20 (PEAK_TRACK_EN) -> peak_idx=1, peak_mag=40, peak_freq=f_start+f_step.
// - samples 3,4,4,5 at one point -> pt_mag=4 (sum 16>>2); meas_valid during SETTLE ignored.
// - abort during MEASURE of point 2 -> IDLE next cycle, no further pt_valid, no done; restart works from idx 0.
// - f_start=2**FW-50, f_step=100, n_points=2 -> pt_freq 2**FW-50 then 50 (wrap); rst_n low mid-SETTLE -> all outputs 0.

Source files
------------

// File: rtl/ac_sweep_pkg.sv
// Shared types and constants for the AC sweep sequencer.
// Optional feature macro used by the top level: PEAK_TRACK_EN.
package ac_sweep_pkg;

  // Width of point indices and of the point-count configuration.
  localparam int IDX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PROGRAM,
    SETTLE,
    MEASURE,
    EVAL,
    DONE
  } sweep_state_e;

  // True in every state that belongs to an active sweep point.
  function automatic logic in_sweep(sweep_state_e s);
    return (s == PROGRAM) || (s == SETTLE) || (s == MEASURE) || (s == EVAL);
  endfunction

endpackage

// File: rtl/sweep_avg_acc.sv
// Sample averager: counts and sums 2**AVG_LOG2 detector magnitudes.
// 'full' flags that the sample being added this cycle completes the set,
// so the caller can leave the measure phase on that same edge; 'avg' is
// the registered sum shifted down, valid the cycle after the final add.
module sweep_avg_acc #(
  parameter int MW       = 24,
  parameter int AVG_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          add,
  input  logic [MW-1:0] sample,
  output logic          full,
  output logic [MW-1:0] avg
);

  // Sum of 2**AVG_LOG2 values of MW bits never exceeds MW+AVG_LOG2 bits.
  localparam int AW = MW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;

  assign full = add && (cnt == LAST);
  assign avg  = MW'(sum >> AVG_LOG2);

  // Running sum and sample count; clear has priority over add.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (clear) begin
      sum <= '0;
      cnt <= '0;
    end else if (add) begin
      sum <= sum + {{AVG_LOG2{1'b0}}, sample};
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ac_sweep_sequencer.sv
// Linear AC frequency sweep sequencer: programs the source point by point,
// waits a settle interval, averages detector magnitudes and streams one
// result per point. Define PEAK_TRACK_EN to track the peak-magnitude point;
// without it the peak outputs are tied to zero.
module ac_sweep_sequencer
  import ac_sweep_pkg::*;
#(
  parameter int FW       = 32,
  parameter int MW       = 24,
  parameter int SETTLE_W = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [FW-1:0]       f_start,
  input  logic [FW-1:0]       f_step,
  input  logic [IDX_W-1:0]    n_points,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic [FW-1:0]       src_freq,
  output logic                src_req,
  input  logic                src_ack,
  output logic                meas_req,
  input  logic                meas_valid,
  input  logic [MW-1:0]       meas_mag,
  output logic                pt_valid,
  output logic [IDX_W-1:0]    pt_idx,
  output logic [FW-1:0]       pt_freq,
  output logic [MW-1:0]       pt_mag,
  output logic                busy,
  output logic                done,
  output logic [FW-1:0]       peak_freq,
  output logic [MW-1:0]       peak_mag,
  output logic [IDX_W-1:0]    peak_idx
);

  sweep_state_e state, next_state;

  logic [FW-1:0]       cur_freq;
  logic [FW-1:0]       step_freq;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    last_idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SETTLE_W:0]   settle_next;
  logic                settle_done;

  logic load;
  logic advance;
  logic eval_ok;
  logic acc_clear;
  logic acc_add;
  logic acc_full;
  logic [MW-1:0] avg_mag;

  // Settle ends once settle_cyc cycles have elapsed; the extra bit keeps a
  // settle_cyc changed to zero mid-wait from looping through the counter.
  assign settle_next = {1'b0, settle_cnt} + 1'b1;
  assign settle_done = settle_next >= {1'b0, settle_cyc};

  // The accumulator only sees samples in MEASURE, and starts each point empty.
  assign acc_add   = (state == MEASURE) && meas_valid && !abort;
  assign acc_clear = (state != MEASURE) || abort;

  sweep_avg_acc #(
    .MW       (MW),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .add    (acc_add),
    .sample (meas_mag),
    .full   (acc_full),
    .avg    (avg_mag)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode and handshake strobes; abort overrides every transition.
  // NOTE: every signal written here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    next_state = state;
    src_req    = 1'b0;
    meas_req   = 1'b0;
    eval_ok    = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = (n_points == '0) ? DONE : PROGRAM;
        end
      end
      PROGRAM: begin
        src_req = 1'b1;
        if (abort)        next_state = IDLE;
        else if (src_ack) next_state = (settle_cyc == '0) ? MEASURE : SETTLE;
      end
      SETTLE: begin
        if (abort)            next_state = IDLE;
        else if (settle_done) next_state = MEASURE;
      end
      MEASURE: begin
        meas_req = 1'b1;
        if (abort)         next_state = IDLE;
        else if (acc_full) next_state = EVAL;
      end
      EVAL: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          eval_ok    = 1'b1;
          next_state = (idx == last_idx) ? DONE : PROGRAM;
        end
      end
      DONE: begin
        done       = !abort;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign advance = eval_ok && (idx != last_idx);

  // Sweep configuration capture and per-point frequency/index stepping;
  // the frequency word wraps modulo 2**FW by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_freq  <= '0;
      step_freq <= '0;
      idx       <= '0;
      last_idx  <= '0;
    end else if (load) begin
      cur_freq  <= f_start;
      step_freq <= f_step;
      idx       <= '0;
      last_idx  <= n_points - 1'b1;
    end else if (advance) begin
      cur_freq <= cur_freq + step_freq;
      idx      <= idx + 1'b1;
    end
  end

  // Settle counter runs only while settling and restarts for every point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 settle_cnt <= '0;
    else if (state == SETTLE)   settle_cnt <= settle_cnt + 1'b1;
    else                        settle_cnt <= '0;
  end

  assign busy     = in_sweep(state);
  assign src_freq = src_req ? cur_freq : '0;
  assign pt_valid = eval_ok;
  assign pt_idx   = eval_ok ? idx      : '0;
  assign pt_freq  = eval_ok ? cur_freq : '0;
  assign pt_mag   = eval_ok ? avg_mag  : '0;

`ifdef PEAK_TRACK_EN
  logic [FW-1:0]    pk_freq;
  logic [MW-1:0]    pk_mag;
  logic [IDX_W-1:0] pk_idx;

  // Peak tracker: cleared on an accepted start, strict compare keeps the
  // first of equal maxima; an aborted sweep leaves the last values in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_freq <= '0;
      pk_mag  <= '0;
      pk_idx  <= '0;
    end else if (load) begin
      pk_freq <= '0;
      pk_mag  <= '0;
      pk_idx  <= '0;
    end else if (eval_ok && (avg_mag > pk_mag)) begin
      pk_freq <= cur_freq;
      pk_mag  <= avg_mag;
      pk_idx  <= idx;
    end
  end

  assign peak_freq = pk_freq;
  assign peak_mag  = pk_mag;
  assign peak_idx  = pk_idx;
`else
  assign peak_freq = '0;
  assign peak_mag  = '0;
  assign peak_idx  = '0;
`endif

endmodule

// File: tb/tb_ac_sweep_sequencer.sv
// Scoreboard bench for ac_sweep_sequencer: each sweep's expected points are
// computed arithmetically at launch; bus-functional source/detector models
// answer the handshakes and a monitor pops and compares every pt_valid.
`timescale 1ns/1ps
module tb_ac_sweep_sequencer;

  localparam int FW = 32;
  localparam int MW = 24;
  localparam int SW = 16;
  localparam int AL = 2;
  localparam int NS = 1 << AL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] f_start = '0;
  logic [FW-1:0] f_step = '0;
  logic [15:0]   n_points = '0;
  logic [SW-1:0] settle_cyc = '0;
  logic [FW-1:0] src_freq;
  logic          src_req;
  logic          src_ack = 1'b0;
  logic          meas_req;
  logic          meas_valid = 1'b0;
  logic [MW-1:0] meas_mag = '0;
  logic          pt_valid;
  logic [15:0]   pt_idx;
  logic [FW-1:0] pt_freq;
  logic [MW-1:0] pt_mag;
  logic          busy;
  logic          done;
  logic [FW-1:0] peak_freq;
  logic [MW-1:0] peak_mag;
  logic [15:0]   peak_idx;

  ac_sweep_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_points(n_points), .settle_cyc(settle_cyc),
    .src_freq(src_freq), .src_req(src_req), .src_ack(src_ack),
    .meas_req(meas_req), .meas_valid(meas_valid), .meas_mag(meas_mag),
    .pt_valid(pt_valid), .pt_idx(pt_idx), .pt_freq(pt_freq), .pt_mag(pt_mag),
    .busy(busy), .done(done),
    .peak_freq(peak_freq), .peak_mag(peak_mag), .peak_idx(peak_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [FW-1:0] freq;
    logic [MW-1:0] mag;
  } pt_t;

  pt_t           exp_q[$];
  logic [MW-1:0] det_q[$];
  logic [MW-1:0] plan[$];
  int            pt_cyc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pt_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  bit busy_seen = 0;
  bit src_seen = 0;
  bit fast_ack = 0;
  bit fast_meas = 0;
  bit junk_all = 0;
  int ack_wait = 0;

  logic [FW-1:0] m_pk_freq;
  logic [MW-1:0] m_pk_mag;
  logic [15:0]   m_pk_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops one expected point per pt_valid, tracks done/busy/src_req.
  always @(negedge clk) begin
    pt_t e;
    if (rst_n) begin
      if (busy)    busy_seen = 1;
      if (src_req) src_seen = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pt_valid) begin
        pt_cnt++;
        pt_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pt_unexpected actual_idx=%0d required=no point", pt_idx);
        end else begin
          e = exp_q.pop_front();
          check("pt_idx", pt_idx, e.idx);
          check("pt_freq", pt_freq, e.freq);
          check("pt_mag", pt_mag, e.mag);
        end
      end
    end
  end

  // Source model: acks after 0..2 cycles (or at once); stray acks outside requests.
  always @(negedge clk) begin
    if (!rst_n) begin
      src_ack = 1'b0;
    end else if (src_req) begin
      if (ack_wait == 0) begin
        src_ack = 1'b1;
        if (exp_q.size() > 0) check("src_freq", src_freq, exp_q[0].freq);
        else begin
          checks++;
          errors++;
          $display("FAIL src_req_unexpected actual_freq=%0d required=no request", src_freq);
        end
      end else begin
        ack_wait--;
        src_ack = 1'b0;
      end
    end else begin
      src_ack  = ($urandom_range(0, 3) == 0);
      ack_wait = fast_ack ? 0 : int'($urandom_range(0, 2));
    end
  end

  // Detector model: feeds planned samples while meas_req, junk otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      meas_valid = 1'b0;
    end else if (meas_req) begin
      if (det_q.size() > 0 && (fast_meas || $urandom_range(0, 3) != 0)) begin
        meas_valid = 1'b1;
        meas_mag   = det_q.pop_front();
      end else begin
        meas_valid = 1'b0;
        meas_mag   = MW'($urandom);
      end
    end else begin
      meas_valid = junk_all ? 1'b1 : 1'($urandom_range(0, 1));
      meas_mag   = MW'($urandom);
    end
  end

  task automatic flush();
    exp_q.delete();
    det_q.delete();
    plan.delete();
  endtask

  task automatic plan_pt(input logic [MW-1:0] a, b, c, d);
    plan.push_back(a); plan.push_back(b); plan.push_back(c); plan.push_back(d);
  endtask

  task automatic plan_rand(input int np);
    for (int i = 0; i < np * NS; i++) plan.push_back(MW'($urandom));
  endtask

  // Build expected results from the plan, then pulse start.
  task automatic launch(input logic [FW-1:0] fs, input logic [FW-1:0] st,
                        input int np, input int sc);
    logic [MW+AL-1:0] sum;
    pt_t e;
    m_pk_freq = '0;
    m_pk_mag  = '0;
    m_pk_idx  = '0;
    for (int i = 0; i < np; i++) begin
      sum = '0;
      for (int k = 0; k < NS; k++) begin
        sum = sum + {{AL{1'b0}}, plan[i*NS+k]};
        det_q.push_back(plan[i*NS+k]);
      end
      e.idx  = i;
      e.freq = fs + st * FW'(i);
      e.mag  = MW'(sum / NS);
      exp_q.push_back(e);
      if (e.mag > m_pk_mag) begin
        m_pk_mag  = e.mag;
        m_pk_idx  = 16'(i);
        m_pk_freq = e.freq;
      end
    end
    plan.delete();
    @(posedge clk); #1;
    f_start    = fs;
    f_step     = st;
    n_points   = 16'(np);
    settle_cyc = SW'(sc);
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
    f_start  = $urandom;
    f_step   = $urandom;
    n_points = 16'($urandom);
  endtask

  // Wait (bounded) for done, then check completion state and peak.
  task automatic finish_sweep(input int base_done, input string tag);
    int n = 0;
    while (done_cnt == base_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != base_done, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - base_done, 1);
    check({tag, "_pts_left"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, busy, 0);
`ifdef PEAK_TRACK_EN
    check({tag, "_peak_mag"}, peak_mag, m_pk_mag);
    check({tag, "_peak_idx"}, peak_idx, m_pk_idx);
    check({tag, "_peak_freq"}, peak_freq, m_pk_freq);
`else
    check({tag, "_peak_mag"}, peak_mag, 0);
    check({tag, "_peak_idx"}, peak_idx, 0);
    check({tag, "_peak_freq"}, peak_freq, 0);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_src_req"}, src_req, 0);
    check({tag, "_src_freq"}, src_freq, 0);
    check({tag, "_meas_req"}, meas_req, 0);
    check({tag, "_pt_valid"}, pt_valid, 0);
    check({tag, "_pt_idx"}, pt_idx, 0);
    check({tag, "_pt_freq"}, pt_freq, 0);
    check({tag, "_pt_mag"}, pt_mag, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_peak_freq"}, peak_freq, 0);
    check({tag, "_peak_mag"}, peak_mag, 0);
    check({tag, "_peak_idx"}, peak_idx, 0);
  endtask

  initial begin
    int base;
    int n;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    #2 rst_n = 1'b1;

    // Constant magnitude, immediate handshakes: latency 1+settle+NS+1 per point.
    fast_ack  = 1;
    fast_meas = 1;
    for (int i = 0; i < 4 * NS; i++) plan.push_back(MW'(50));
    pt_cyc_q.delete();
    base = done_cnt;
    launch(32'd1000, 32'd100, 4, 3);
    finish_sweep(base, "const");
    check("const_pt_count", pt_cyc_q.size(), 4);
    for (int i = 0; i < 4 && i < pt_cyc_q.size(); i++)
      check("const_latency", pt_cyc_q[i] - start_cyc, (1 + 3 + NS + 1) * (i + 1));
    fast_ack  = 0;
    fast_meas = 0;

    // Empty sweep: straight to done, never busy, no source request.
    busy_seen = 0;
    src_seen  = 0;
    base = done_cnt;
    launch(32'd1234, 32'd5, 0, 2);
    finish_sweep(base, "zero");
    check("zero_done_latency_ok", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
    check("zero_busy_seen", busy_seen, 0);
    check("zero_src_seen", src_seen, 0);

    // Peak location with a tie: first maximum wins.
    plan_pt(10, 10, 10, 10);
    plan_pt(40, 40, 40, 40);
    plan_pt(40, 40, 40, 40);
    plan_pt(20, 20, 20, 20);
    base = done_cnt;
    launch(32'd5000, 32'd250, 4, 1);
    finish_sweep(base, "peak");

    // Averaging with truncating shift; junk samples during settle must not count.
    junk_all = 1;
    plan_pt(3, 4, 4, 5);
    base = done_cnt;
    launch(32'd777, 32'd1, 1, 4);
    finish_sweep(base, "avg");
    junk_all = 0;

    // Abort during MEASURE of point 2, with a start in the same cycle.
    plan_rand(4);
    base = done_cnt;
    n = 0;
    launch(32'd20000, 32'd300, 4, 2);
    base = pt_cnt;
    while (pt_cnt < base + 2 && n < 500) begin @(negedge clk); n++; end
    check("abort_reach_pt2", pt_cnt >= base + 2, 1);
    n = 0;
    while (!meas_req && n < 200) begin @(negedge clk); n++; end
    check("abort_in_measure", meas_req, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    start = 1'b1;
    f_start = 32'd9;
    n_points = 16'd3;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    flush();
    base = done_cnt;
    busy_seen = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_src_req", src_req, 0);
    check("abort_meas_req", meas_req, 0);
    repeat (30) @(negedge clk);
    check("abort_busy_seen", busy_seen, 0);
    check("abort_no_done", done_cnt - base, 0);

    // Restart after abort begins again at index 0.
    plan_rand(3);
    base = done_cnt;
    launch(32'd40, 32'd7, 3, 1);
    finish_sweep(base, "restart");

    // Frequency word wraps modulo 2**FW; settle of zero skips straight to MEASURE.
    plan_rand(2);
    base = done_cnt;
    launch(32'hFFFF_FFCE, 32'd100, 2, 0);
    finish_sweep(base, "wrap");

    // Randomised sweeps.
    for (int r = 0; r < 5; r++) begin
      plan_rand(int'($urandom_range(1, 5)));
      base = done_cnt;
      launch($urandom, $urandom, plan.size() / NS, int'($urandom_range(0, 4)));
      finish_sweep(base, "rand");
    end

    // Async reset in the middle of SETTLE.
    plan_rand(2);
    base = done_cnt;
    launch(32'd3000, 32'd10, 2, 25);
    n = 0;
    while (!src_req && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (src_req && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1 check_zero("rst_mid");
    flush();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", done_cnt - base, 0);

    // Normal operation after reset.
    plan_rand(2);
    base = done_cnt;
    launch(32'd100, 32'd1, 2, 1);
    finish_sweep(base, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
